// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for the 5-stage Y86-64 PIPE core: tracks E/M/W destination tags,
// selects decode operand forwarding and generates stall/bubble controls.
module pipe_hazard_ctrl #(
  parameter logic [3:0]  RNone = 4'hF,
  parameter int unsigned IcW   = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           d_valid_i,
  input  logic [IcW-1:0] d_icode_i,
  input  logic [3:0]     d_src_a_i,
  input  logic [3:0]     d_src_b_i,
  input  logic [3:0]     d_dst_e_i,
  input  logic [3:0]     d_dst_m_i,
  input  logic           e_cnd_i,
  output logic [2:0]     fwd_a_sel_o,
  output logic [2:0]     fwd_b_sel_o,
  output logic           f_stall_o,
  output logic           d_stall_o,
  output logic           d_bubble_o,
  output logic           e_bubble_o,
  output logic [3:0]     m_dst_e_o,
  output logic [3:0]     m_dst_m_o,
  output logic [3:0]     w_dst_e_o,
  output logic [3:0]     w_dst_m_o,
  output logic           halted_o
);

  localparam logic [IcW-1:0] IHalt  = IcW'(4'h0);
  localparam logic [IcW-1:0] INop   = IcW'(4'h1);
  localparam logic [IcW-1:0] ICmov  = IcW'(4'h2);
  localparam logic [IcW-1:0] IMrmov = IcW'(4'h5);
  localparam logic [IcW-1:0] IJxx   = IcW'(4'h7);
  localparam logic [IcW-1:0] ICall  = IcW'(4'h8);
  localparam logic [IcW-1:0] IRet   = IcW'(4'h9);
  localparam logic [IcW-1:0] IPop   = IcW'(4'hB);

  typedef struct packed {
    logic           valid;
    logic [IcW-1:0] icode;
    logic [3:0]     dst_e;
    logic [3:0]     dst_m;
  } tag_t;

  localparam tag_t NopTag = '{valid: 1'b0, icode: INop, dst_e: RNone, dst_m: RNone};

  tag_t e_q, e_d, m_q, m_d, w_q, w_d;
  logic halted_q, halted_d;

  logic [3:0] e_dst_e_eff;
  logic       w_halt, load_use, mispredict, ret_busy, d_is_valp;

  function automatic logic hit(input logic v, input logic [3:0] tag, input logic [3:0] src);
    return v && (tag != RNone) && (tag == src);
  endfunction

  // A not-taken cmov squashes its own destination.
  assign e_dst_e_eff = (e_q.icode == ICmov && !e_cnd_i) ? RNone : e_q.dst_e;

  assign w_halt     = w_q.valid && (w_q.icode == IHalt);
  assign halted_o   = halted_q | w_halt;
  assign load_use   = d_valid_i && e_q.valid && (e_q.icode == IMrmov || e_q.icode == IPop) &&
                      (hit(1'b1, e_q.dst_m, d_src_a_i) || hit(1'b1, e_q.dst_m, d_src_b_i));
  assign mispredict = e_q.valid && (e_q.icode == IJxx) && !e_cnd_i;
  assign ret_busy   = (d_valid_i && d_icode_i == IRet) || (e_q.valid && e_q.icode == IRet) ||
                      (m_q.valid && m_q.icode == IRet);
  assign d_is_valp  = (d_icode_i == IJxx) || (d_icode_i == ICall);

  assign f_stall_o  = load_use | ret_busy | halted_o;
  assign d_stall_o  = load_use | halted_o;
  assign d_bubble_o = (mispredict | (ret_busy & ~load_use)) & ~d_stall_o;
  assign e_bubble_o = (mispredict | load_use) & ~halted_o;

  assign m_dst_e_o = m_q.valid ? m_q.dst_e : RNone;
  assign m_dst_m_o = m_q.valid ? m_q.dst_m : RNone;
  assign w_dst_e_o = (w_q.valid && !halted_o) ? w_q.dst_e : RNone;
  assign w_dst_m_o = (w_q.valid && !halted_o) ? w_q.dst_m : RNone;

  always_comb begin
    fwd_a_sel_o = 3'd0;
    if (!d_valid_i)                                    fwd_a_sel_o = 3'd0;
    else if (d_is_valp)                                fwd_a_sel_o = 3'd6;
    else if (hit(e_q.valid, e_dst_e_eff, d_src_a_i))   fwd_a_sel_o = 3'd1;
    else if (hit(m_q.valid, m_q.dst_m, d_src_a_i))     fwd_a_sel_o = 3'd2;
    else if (hit(m_q.valid, m_q.dst_e, d_src_a_i))     fwd_a_sel_o = 3'd3;
    else if (hit(w_q.valid, w_q.dst_m, d_src_a_i))     fwd_a_sel_o = 3'd4;
    else if (hit(w_q.valid, w_q.dst_e, d_src_a_i))     fwd_a_sel_o = 3'd5;
  end

  always_comb begin
    fwd_b_sel_o = 3'd0;
    if (!d_valid_i)                                    fwd_b_sel_o = 3'd0;
    else if (hit(e_q.valid, e_dst_e_eff, d_src_b_i))   fwd_b_sel_o = 3'd1;
    else if (hit(m_q.valid, m_q.dst_m, d_src_b_i))     fwd_b_sel_o = 3'd2;
    else if (hit(m_q.valid, m_q.dst_e, d_src_b_i))     fwd_b_sel_o = 3'd3;
    else if (hit(w_q.valid, w_q.dst_m, d_src_b_i))     fwd_b_sel_o = 3'd4;
    else if (hit(w_q.valid, w_q.dst_e, d_src_b_i))     fwd_b_sel_o = 3'd5;
  end

  always_comb begin
    e_d      = e_q;
    m_d      = m_q;
    w_d      = w_q;
    halted_d = halted_o;
    // Once halt reaches W the whole tracked pipeline freezes.
    if (!halted_o) begin
      w_d       = m_q;
      m_d       = e_q;
      m_d.dst_e = e_dst_e_eff;
      if (e_bubble_o || !d_valid_i) begin
        e_d = NopTag;
      end else begin
        e_d = '{valid: 1'b1, icode: d_icode_i, dst_e: d_dst_e_i, dst_m: d_dst_m_i};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      e_q      <= NopTag;
      m_q      <= NopTag;
      w_q      <= NopTag;
      halted_q <= 1'b0;
    end else begin
      e_q      <= e_d;
      m_q      <= m_d;
      w_q      <= w_d;
      halted_q <= halted_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a list-based model of in-flight instructions
// predicts every output each cycle; a monitor compares at the falling edge.
module tb_pipe_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       d_valid = 1'b0;
  logic [3:0] d_icode = 4'h1, d_src_a = 4'hF, d_src_b = 4'hF, d_dst_e = 4'hF, d_dst_m = 4'hF;
  logic       e_cnd = 1'b0;
  logic [2:0] fwd_a_sel, fwd_b_sel;
  logic       f_stall, d_stall, d_bubble, e_bubble, halted;
  logic [3:0] m_dst_e, m_dst_m, w_dst_e, w_dst_m;

  pipe_hazard_ctrl dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .d_valid_i   (d_valid),
    .d_icode_i   (d_icode),
    .d_src_a_i   (d_src_a),
    .d_src_b_i   (d_src_b),
    .d_dst_e_i   (d_dst_e),
    .d_dst_m_i   (d_dst_m),
    .e_cnd_i     (e_cnd),
    .fwd_a_sel_o (fwd_a_sel),
    .fwd_b_sel_o (fwd_b_sel),
    .f_stall_o   (f_stall),
    .d_stall_o   (d_stall),
    .d_bubble_o  (d_bubble),
    .e_bubble_o  (e_bubble),
    .m_dst_e_o   (m_dst_e),
    .m_dst_m_o   (m_dst_m),
    .w_dst_e_o   (w_dst_e),
    .w_dst_m_o   (w_dst_m),
    .halted_o    (halted)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [2:0] fa, fb;
    logic       fs, ds, db, eb;
    logic [3:0] mde, mdm, wde, wdm;
    logic       h;
  } obs_t;

  typedef struct { bit v; int ic; int de; int dm; } ins_t;

  ins_t pipe[3];  // 0: E, 1: M, 2: W
  bit   hq;
  obs_t exp_q[$];
  obs_t obs_dut;
  int   n_cmp = 0, n_fail = 0;

  assign obs_dut = {fwd_a_sel, fwd_b_sel, f_stall, d_stall, d_bubble, e_bubble,
                    m_dst_e, m_dst_m, w_dst_e, w_dst_m, halted};

  function automatic ins_t nop_ins();
    ins_t n;
    n.v = 0; n.ic = 1; n.de = 15; n.dm = 15;
    return n;
  endfunction

  function automatic int eff_dst_e();
    return (pipe[0].ic == 2 && !e_cnd) ? 15 : pipe[0].de;
  endfunction

  // Newest producer wins; within M the loaded value beats the ALU value.
  function automatic logic [2:0] lookup(input int src);
    int tag[5];
    bit vv[5];
    tag[0] = eff_dst_e();  vv[0] = pipe[0].v;
    tag[1] = pipe[1].dm;   vv[1] = pipe[1].v;
    tag[2] = pipe[1].de;   vv[2] = pipe[1].v;
    tag[3] = pipe[2].dm;   vv[3] = pipe[2].v;
    tag[4] = pipe[2].de;   vv[4] = pipe[2].v;
    for (int k = 0; k < 5; k++)
      if (vv[k] && tag[k] != 15 && tag[k] == src) return 3'(k + 1);
    return 3'd0;
  endfunction

  function automatic obs_t model_eval();
    obs_t o;
    bit h, lu, mp, rb;
    int ic;
    ic = int'(d_icode);
    h  = hq || (pipe[2].v && pipe[2].ic == 0);
    lu = d_valid && pipe[0].v && (pipe[0].ic == 5 || pipe[0].ic == 11) && pipe[0].dm != 15 &&
         (pipe[0].dm == int'(d_src_a) || pipe[0].dm == int'(d_src_b));
    mp = pipe[0].v && pipe[0].ic == 7 && !e_cnd;
    rb = (d_valid && ic == 9) || (pipe[0].v && pipe[0].ic == 9) || (pipe[1].v && pipe[1].ic == 9);
    o.fa = !d_valid ? 3'd0 : (ic == 7 || ic == 8) ? 3'd6 : lookup(int'(d_src_a));
    o.fb = !d_valid ? 3'd0 : lookup(int'(d_src_b));
    if (h) begin
      o.fs = 1; o.ds = 1; o.db = 0; o.eb = 0;
    end else begin
      o.fs = lu | rb;
      o.ds = lu;
      o.db = (mp | (rb & !lu)) & !lu;
      o.eb = mp | lu;
    end
    o.mde = pipe[1].v ? 4'(pipe[1].de) : 4'hF;
    o.mdm = pipe[1].v ? 4'(pipe[1].dm) : 4'hF;
    o.wde = (pipe[2].v && !h) ? 4'(pipe[2].de) : 4'hF;
    o.wdm = (pipe[2].v && !h) ? 4'(pipe[2].dm) : 4'hF;
    o.h   = h;
    return o;
  endfunction

  task automatic model_clock();
    obs_t o;
    ins_t nw;
    int   eff;
    if (!rst_ni) begin
      for (int k = 0; k < 3; k++) pipe[k] = nop_ins();
      hq = 0;
    end else begin
      o   = model_eval();
      eff = eff_dst_e();
      if (!o.h) begin
        nw = nop_ins();
        if (d_valid && !o.eb) begin
          nw.v = 1; nw.ic = int'(d_icode); nw.de = int'(d_dst_e); nw.dm = int'(d_dst_m);
        end
        pipe[2]    = pipe[1];
        pipe[1]    = pipe[0];
        pipe[1].de = eff;
        pipe[0]    = nw;
      end
      hq = o.h;
    end
  endtask

  task automatic step(input logic v, input logic [3:0] ic, input logic [3:0] sa,
                      input logic [3:0] sb, input logic [3:0] de, input logic [3:0] dm,
                      input logic c);
    @(posedge clk_i);
    model_clock();
    #1;
    d_valid = v; d_icode = ic; d_src_a = sa; d_src_b = sb; d_dst_e = de; d_dst_m = dm; e_cnd = c;
    exp_q.push_back(model_eval());
  endtask

  task automatic nop_step(input logic c);
    step(1'b1, 4'h1, 4'hF, 4'hF, 4'hF, 4'hF, c);
  endtask

  task automatic flush();
    repeat (4) nop_step(1'b1);
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic sample();
    @(negedge clk_i);
    #1;
  endtask

  // Reset is applied between edges and must act without a clock.
  task automatic async_reset();
    sample();
    #1;
    d_valid = 1'b0;
    rst_ni  = 1'b0;
    #1;
    chk("reset_wdst", int'({w_dst_e, w_dst_m}), 'hFF);
    chk("reset_ctl", int'({f_stall, d_stall, d_bubble, e_bubble, halted}), 0);
    step(1'b0, 4'h1, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0);
    sample();
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (obs_dut !== e) begin
          n_fail++;
          $display("FAIL outputs @%0t: got %h required %h", $time, obs_dut, e);
        end
      end
    end
  end

  initial begin : driver
    logic [3:0] ics [11];
    logic [3:0] r [4];
    for (int k = 0; k < 11; k++) ics[k] = 4'(k + 1);
    for (int k = 0; k < 3; k++) pipe[k] = nop_ins();
    hq = 0;

    #3;
    chk("por_wdst", int'({w_dst_e, w_dst_m}), 'hFF);
    chk("por_ctl", int'({f_stall, d_stall, d_bubble, e_bubble, halted}), 0);
    repeat (2) step(1'b0, 4'h1, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0);
    sample();
    rst_ni = 1'b1;

    // Forwarding distance: irmovq dstE=2 then OPq srcA=2 after 0..3 nops.
    for (int gap = 0; gap < 4; gap++) begin
      flush();
      step(1'b1, 4'h3, 4'hF, 4'hF, 4'h2, 4'hF, 1'b1);
      repeat (gap) nop_step(1'b1);
      step(1'b1, 4'h6, 4'h2, 4'h5, 4'h5, 4'hF, 1'b1);
      sample();
      chk($sformatf("fwdA_gap%0d", gap), int'(fwd_a_sel), (gap == 0) ? 1 : (gap == 1) ? 3 :
          (gap == 2) ? 5 : 0);
    end

    // Load-use: one stall cycle then forward from m_valM.
    flush();
    step(1'b1, 4'h5, 4'hF, 4'hF, 4'hF, 4'h3, 1'b1);
    step(1'b1, 4'h6, 4'h6, 4'h3, 4'h3, 4'hF, 1'b1);
    sample();
    chk("loaduse_ctl", int'({f_stall, d_stall, e_bubble}), 'b111);
    step(1'b1, 4'h6, 4'h6, 4'h3, 4'h3, 4'hF, 1'b1);
    sample();
    chk("loaduse_fwdB", int'(fwd_b_sel), 2);
    chk("loaduse_clear", int'({f_stall, d_stall, e_bubble}), 0);

    // Mispredicted and correctly predicted jXX.
    for (int c = 0; c < 2; c++) begin
      flush();
      step(1'b1, 4'h7, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1);
      sample();
      chk("jxx_fwdA_valp", int'(fwd_a_sel), 6);
      nop_step(1'(c));
      sample();
      chk($sformatf("jxx_bubbles_cnd%0d", c), int'({d_bubble, e_bubble}), (c == 0) ? 'b11 : 0);
    end

    // ret holds fetch for three cycles.
    flush();
    step(1'b1, 4'h9, 4'h4, 4'h4, 4'h4, 4'hF, 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step(1'b0, 4'h1, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1);
      sample();
      chk($sformatf("ret_cycle%0d", k), int'({f_stall, d_bubble}), (k < 3) ? 'b11 : 0);
    end

    // cmov destination squash and pass-through.
    for (int c = 0; c < 2; c++) begin
      flush();
      step(1'b1, 4'h2, 4'h1, 4'hF, 4'h4, 4'hF, 1'b1);
      nop_step(1'(c));
      nop_step(1'b1);
      sample();
      chk($sformatf("cmov_mdstE_cnd%0d", c), int'(m_dst_e), (c == 0) ? 'hF : 4);
      nop_step(1'b1);
      sample();
      chk($sformatf("cmov_wdstE_cnd%0d", c), int'(w_dst_e), (c == 0) ? 'hF : 4);
    end

    // Randomised traffic with occasional asynchronous resets.
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < 4; k++) begin
        r[k] = 4'($urandom_range(0, 5));
        if (r[k] == 4'd5) r[k] = 4'hF;
        else if (r[k] == 4'd4) r[k] = 4'($urandom_range(0, 14));
      end
      step(1'($urandom_range(0, 9) != 0), ics[$urandom_range(0, 10)], r[0], r[1], r[2], r[3],
           1'($urandom_range(0, 1)));
      if ($urandom_range(0, 299) == 0) async_reset();
    end

    // halt: halted appears three cycles after D and sticks until reset.
    flush();
    step(1'b1, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, 4'h3, 4'hF, 4'hF, 4'h2, 4'hF, 1'b1);
      sample();
      chk($sformatf("halt_cycle%0d", k), int'(halted), (k >= 3) ? 1 : 0);
      if (k >= 3) chk($sformatf("halt_wdst%0d", k), int'({w_dst_e, w_dst_m}), 'hFF);
    end
    async_reset();
    flush();
    sample();
    chk("post_reset_halted", int'(halted), 0);
    chk("post_reset_wdstE", int'(w_dst_e), 'hF);

    sample();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
